decode_execute_stage: RTL and testbench

Parametrised, elastic decode-to-execute pipeline stage for the MiniMIPS core. It is the successor to the fixed-width ID/EX register.
- Carries the control vector, two register operands, the immediate and three register addresses from decode to execute.
- Adds valid/ready handshaking with a 2-entry skid buffer, so back-pressure from execute never loses an instruction.
- Synchronous flush turns all in-flight entries into zeroed bubbles.

---
 rtl/decode_execute_stage.sv | 137 +++++++++++++
 tb/tb_decode_execute_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_execute_stage.sv
// Elastic decode-to-execute pipeline stage with a 2-entry skid buffer and synchronous flush.
// Optional saturating performance counters are enabled with `define DE_PERF_EN.
module decode_execute_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned IMM_W   = 32,
  parameter int unsigned CTRL_W  = 8,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CLR,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  ctrl_d,
  input  logic [DATA_W-1:0]  rd1_d,
  input  logic [DATA_W-1:0]  rd2_d,
  input  logic [IMM_W-1:0]   imm_d,
  input  logic [RADDR_W-1:0] rs_d,
  input  logic [RADDR_W-1:0] rt_d,
  input  logic [RADDR_W-1:0] rd_d,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  ctrl_e,
  output logic [DATA_W-1:0]  rd1_e,
  output logic [DATA_W-1:0]  rd2_e,
  output logic [IMM_W-1:0]   imm_e,
  output logic [RADDR_W-1:0] rs_e,
  output logic [RADDR_W-1:0] rt_e,
  output logic [RADDR_W-1:0] rd_e
`ifdef DE_PERF_EN
  ,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
`endif
);

  localparam int unsigned PayW = CTRL_W + 2 * DATA_W + IMM_W + 3 * RADDR_W;

  logic [PayW-1:0] in_pay;
  logic [PayW-1:0] m_pay_q, m_pay_d;
  logic [PayW-1:0] s_pay_q, s_pay_d;
  logic            m_valid_q, m_valid_d;
  logic            s_valid_q, s_valid_d;
  logic            in_fire;
  logic            out_fire;

  assign in_pay   = {ctrl_d, rd1_d, rd2_d, imm_d, rs_d, rt_d, rd_d};
  assign in_ready = ~s_valid_q;
  assign in_fire  = in_valid & ~s_valid_q;
  assign out_valid = m_valid_q;
  assign out_fire = m_valid_q & out_ready;

  // Invalid entries always carry a zero payload so the outputs read as a NOP bubble.
  always_comb begin
    m_valid_d = m_valid_q;
    m_pay_d   = m_pay_q;
    s_valid_d = s_valid_q;
    s_pay_d   = s_pay_q;
    if (CLR) begin
      m_valid_d = 1'b0;
      m_pay_d   = '0;
      s_valid_d = 1'b0;
      s_pay_d   = '0;
    end else if (!m_valid_q || out_fire) begin
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_pay_d   = s_pay_q;
        s_valid_d = 1'b0;
        s_pay_d   = '0;
      end else if (in_fire) begin
        m_valid_d = 1'b1;
        m_pay_d   = in_pay;
      end else begin
        m_valid_d = 1'b0;
        m_pay_d   = '0;
      end
    end else if (in_fire) begin
      s_valid_d = 1'b1;
      s_pay_d   = in_pay;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_valid_q <= 1'b0;
      m_pay_q   <= '0;
      s_valid_q <= 1'b0;
      s_pay_q   <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_pay_q   <= m_pay_d;
      s_valid_q <= s_valid_d;
      s_pay_q   <= s_pay_d;
    end
  end

  assign {ctrl_e, rd1_e, rd2_e, imm_e, rs_e, rt_e, rd_e} = m_pay_q;

`ifdef DE_PERF_EN
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  always_comb begin
    bubble_d = bubble_q;
    stall_d  = stall_q;
    flush_d  = flush_q;
    if (!m_valid_q && bubble_q != CntMax) bubble_d = bubble_q + 1'b1;
    if (m_valid_q && !out_ready && stall_q != CntMax) stall_d = stall_q + 1'b1;
    if (CLR && flush_q != CntMax) flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bubble_q <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      bubble_q <= bubble_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
    end
  end

  assign bubble_cnt = bubble_q;
  assign stall_cnt  = stall_q;
  assign flush_cnt  = flush_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_decode_execute_stage.sv
// Self-checking bench for decode_execute_stage: directed steps plus random traffic checked
// against a 2-deep FIFO reference model; a wide instance checks parameter scaling.
module tb_decode_execute_stage;

  localparam int unsigned CW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NW = 4;
  localparam int unsigned XW = 256;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [IW-1:0] imm;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
  } beat_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          CLR = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] ctrl_d = '0;
  logic [DW-1:0] rd1_d = '0, rd2_d = '0;
  logic [IW-1:0] imm_d = '0;
  logic [AW-1:0] rs_d = '0, rt_d = '0, rd_d = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] ctrl_e;
  logic [DW-1:0] rd1_e, rd2_e;
  logic [IW-1:0] imm_e;
  logic [AW-1:0] rs_e, rt_e, rd_e;
`ifdef DE_PERF_EN
  logic [NW-1:0] bubble_cnt, stall_cnt, flush_cnt;
  logic [15:0]   w_bubble_cnt, w_stall_cnt, w_flush_cnt;
`endif

  // Wide instance
  logic          w_in_valid = 1'b0;
  logic          w_in_ready, w_out_valid;
  logic [11:0]   w_ctrl_d = '0, w_ctrl_e;
  logic [63:0]   w_rd1_d = '0, w_rd2_d = '0, w_rd1_e, w_rd2_e;
  logic [31:0]   w_imm_d = '0, w_imm_e;
  logic [5:0]    w_rs_d = '0, w_rt_d = '0, w_rd_d = '0, w_rs_e, w_rt_e, w_rd_e;

  always #5 CLK = ~CLK;

  decode_execute_stage #(
    .DATA_W(DW), .IMM_W(IW), .CTRL_W(CW), .RADDR_W(AW), .CNT_W(NW)
  ) dut (
    .CLK(CLK), .RST(RST), .CLR(CLR),
    .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_d(ctrl_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d),
    .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
    .out_valid(out_valid), .out_ready(out_ready),
    .ctrl_e(ctrl_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e),
    .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e)
`ifdef DE_PERF_EN
    , .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  decode_execute_stage #(
    .DATA_W(64), .IMM_W(32), .CTRL_W(12), .RADDR_W(6), .CNT_W(16)
  ) dut_wide (
    .CLK(CLK), .RST(RST), .CLR(1'b0),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .ctrl_d(w_ctrl_d), .rd1_d(w_rd1_d), .rd2_d(w_rd2_d), .imm_d(w_imm_d),
    .rs_d(w_rs_d), .rt_d(w_rt_d), .rd_d(w_rd_d),
    .out_valid(w_out_valid), .out_ready(1'b1),
    .ctrl_e(w_ctrl_e), .rd1_e(w_rd1_e), .rd2_e(w_rd2_e), .imm_e(w_imm_e),
    .rs_e(w_rs_e), .rt_e(w_rt_e), .rd_e(w_rd_e)
`ifdef DE_PERF_EN
    , .bubble_cnt(w_bubble_cnt), .stall_cnt(w_stall_cnt), .flush_cnt(w_flush_cnt)
`endif
  );

  beat_t q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    m_bub = 0, m_stl = 0, m_fl = 0;
  localparam int CntMax = (1 << NW) - 1;

  task automatic chk(input string tag, input logic [XW-1:0] obs, input logic [XW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    beat_t exp_b;
    beat_t obs_b;
    exp_b = (q.size() != 0) ? q[0] : '0;
    obs_b = {ctrl_e, rd1_e, rd2_e, imm_e, rs_e, rt_e, rd_e};
    chk({tag, ".out_valid"}, XW'(out_valid), XW'(q.size() != 0));
    chk({tag, ".in_ready"}, XW'(in_ready), XW'(q.size() < 2));
    chk({tag, ".payload"}, XW'(obs_b), XW'(exp_b));
`ifdef DE_PERF_EN
    chk({tag, ".bubble_cnt"}, XW'(bubble_cnt), XW'(m_bub));
    chk({tag, ".stall_cnt"}, XW'(stall_cnt), XW'(m_stl));
    chk({tag, ".flush_cnt"}, XW'(flush_cnt), XW'(m_fl));
`endif
  endtask

  // Drive one cycle's inputs, advance the reference FIFO, then check after the edge.
  task automatic step(input string tag, input logic clr, input logic iv, input logic ordy,
                      input beat_t b);
    bit in_fire, out_fire;
    CLR = clr;
    in_valid = iv;
    out_ready = ordy;
    {ctrl_d, rd1_d, rd2_d, imm_d, rs_d, rt_d, rd_d} = b;
    in_fire  = iv && (q.size() < 2);
    out_fire = ordy && (q.size() != 0);
    if (q.size() == 0 && m_bub < CntMax) m_bub++;
    if (q.size() != 0 && !ordy && m_stl < CntMax) m_stl++;
    if (clr && m_fl < CntMax) m_fl++;
    if (clr) begin
      q.delete();
    end else begin
      if (out_fire) void'(q.pop_front());
      if (in_fire) q.push_back(b);
    end
    @(posedge CLK);
    #1;
    check_state(tag);
  endtask

  task automatic reset_mid_cycle(input string tag);
    in_valid = 1'b1;
    ctrl_d = 8'hFF;
    rd1_d = 32'h1234_5678;
    #3;
    RST = 1'b0;
    q.delete();
    m_bub = 0;
    m_stl = 0;
    m_fl = 0;
    #1;
    check_state({tag, ".async"});
    @(posedge CLK);
    #1;
    check_state({tag, ".held"});
    #2;
    RST = 1'b1;
    in_valid = 1'b0;
    CLR = 1'b0;
    @(posedge CLK);
    #1;
    check_state({tag, ".released"});
  endtask

  function automatic beat_t rnd_beat();
    beat_t b;
    b.ctrl = CW'($urandom);
    b.rd1  = $urandom;
    b.rd2  = $urandom;
    b.imm  = $urandom;
    b.rs   = AW'($urandom);
    b.rt   = AW'($urandom);
    b.rd   = AW'($urandom);
    return b;
  endfunction

  function automatic beat_t mk(input logic [DW-1:0] v);
    beat_t b;
    b = rnd_beat();
    b.rd1 = v;
    return b;
  endfunction

  beat_t ff_beat;

  initial begin
    repeat (2) @(posedge CLK);
    #3;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check_state("reset");

    // Streaming at full rate
    for (int i = 1; i <= 4; i++) begin
      step("stream", 1'b0, 1'b1, 1'b1, mk(DW'(i)));
      chk("stream.rd1_e", XW'(rd1_e), XW'(i));
    end
    step("stream_drain", 1'b0, 1'b0, 1'b1, '0);

    // Back-pressure: A, B, C with out_ready dropped when A appears
    step("bp_a", 1'b0, 1'b1, 1'b1, mk(32'hA));
    chk("bp_a.rd1_e", XW'(rd1_e), XW'(32'hA));
    step("bp_b", 1'b0, 1'b1, 1'b0, mk(32'hB));
    chk("bp_b.rd1_e", XW'(rd1_e), XW'(32'hA));
    chk("bp_b.in_ready", XW'(in_ready), XW'(0));
    step("bp_c_blocked", 1'b0, 1'b1, 1'b0, mk(32'hC));
    chk("bp_c_blocked.rd1_e", XW'(rd1_e), XW'(32'hA));
    step("bp_drain1", 1'b0, 1'b1, 1'b1, mk(32'hC));
    chk("bp_drain1.rd1_e", XW'(rd1_e), XW'(32'hB));
    step("bp_drain2", 1'b0, 1'b1, 1'b1, mk(32'hC));
    chk("bp_drain2.rd1_e", XW'(rd1_e), XW'(32'hC));
    step("bp_drain3", 1'b0, 1'b0, 1'b1, '0);
    chk("bp_drain3.out_valid", XW'(out_valid), XW'(0));

    // Flush with both entries full, input beat dropped
    step("fl_x", 1'b0, 1'b1, 1'b1, rnd_beat());
    step("fl_y", 1'b0, 1'b1, 1'b0, rnd_beat());
    ff_beat = rnd_beat();
    ff_beat.ctrl = 8'hFF;
    step("flush", 1'b1, 1'b1, 1'b0, ff_beat);
    chk("flush.ctrl_e", XW'(ctrl_e), XW'(0));
    chk("flush.rd1_e", XW'(rd1_e), XW'(0));
    chk("flush.in_ready", XW'(in_ready), XW'(1));
    step("flush_after", 1'b0, 1'b0, 1'b0, '0);

    // Flush coinciding with out_fire
    step("fl2_x", 1'b0, 1'b1, 1'b1, rnd_beat());
    step("flush_fire", 1'b1, 1'b1, 1'b1, rnd_beat());

    // Wide instance bit-exactness
    w_in_valid = 1'b1;
    w_ctrl_d = 12'hA5C;
    w_rd1_d = 64'hDEAD_BEEF_0123_4567;
    w_rd2_d = 64'hFEDC_BA98_7654_3210;
    w_imm_d = 32'hFFFF_8001;
    w_rs_d = 6'h3F;
    w_rt_d = 6'h15;
    w_rd_d = 6'h2A;
    step("wide_idle", 1'b0, 1'b0, 1'b1, '0);
    w_in_valid = 1'b0;
    chk("wide.out_valid", XW'(w_out_valid), XW'(1));
    chk("wide.ctrl_e", XW'(w_ctrl_e), XW'(12'hA5C));
    chk("wide.rd1_e", XW'(w_rd1_e), XW'(64'hDEAD_BEEF_0123_4567));
    chk("wide.rd2_e", XW'(w_rd2_e), XW'(64'hFEDC_BA98_7654_3210));
    chk("wide.imm_e", XW'(w_imm_e), XW'(32'hFFFF_8001));
    chk("wide.rs_e", XW'(w_rs_e), XW'(6'h3F));
    chk("wide.rt_rd_e", XW'({w_rt_e, w_rd_e}), XW'({6'h15, 6'h2A}));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(15) == 0), ($urandom_range(3) != 0),
           ($urandom_range(2) != 0), rnd_beat());
    end

    // Asynchronous reset with data in flight
    step("pre_rst_a", 1'b0, 1'b1, 1'b0, rnd_beat());
    step("pre_rst_b", 1'b0, 1'b1, 1'b0, rnd_beat());
    reset_mid_cycle("rst_mid");
    step("post_rst_idle", 1'b0, 1'b0, 1'b1, '0);
    step("post_rst_fire", 1'b0, 1'b1, 1'b1, rnd_beat());

    // Counter scenario: fresh reset, 20 bubbles, 3 stalls, 2 flushes
    reset_mid_cycle("perf_rst");
    for (int i = 0; i < 20; i++) step("perf_bub", 1'b0, 1'b0, 1'b1, '0);
    step("perf_load", 1'b0, 1'b1, 1'b0, rnd_beat());
    for (int i = 0; i < 3; i++) step("perf_stall", 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 2; i++) step("perf_flush", 1'b1, 1'b0, 1'b1, '0);
`ifdef DE_PERF_EN
    chk("perf.bubble_sat", XW'(bubble_cnt), XW'(15));
    chk("perf.stall", XW'(stall_cnt), XW'(3));
    chk("perf.flush", XW'(flush_cnt), XW'(2));
`endif
    reset_mid_cycle("perf_clear");
`ifdef DE_PERF_EN
    chk("perf.cleared", XW'({bubble_cnt, stall_cnt, flush_cnt}), XW'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
